riscv_run_ctrl: RTL and testbench

Synthesisable run controller and result monitor for the single-cycle `riscv_32i` core. It replaces the ad-hoc reset and cycle-limit logic in benches with a parametrised block that:
- sequences the core's reset;
- bounds the run with a cycle timeout;
- detects program halt (`ECALL`/`EBREAK` or a jump-to-self loop);
- captures data-memory writes into a readable signature buffer.

---
 rtl/risc_pkg.sv | 14 +
 rtl/riscv_run_ctrl_if.sv | 39 +++
 rtl/signature_buffer.sv | 65 ++++++
 rtl/riscv_run_ctrl.sv | 132 +++++++++++++
 tb/tb_riscv_run_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the riscv_32i run controller.
package risc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReset = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } run_state_t;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/riscv_run_ctrl_if.sv
// Bundle of core snoop, control and status signals around the run controller.
interface riscv_run_ctrl_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SIG_DEPTH = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  localparam int unsigned IdxW = $clog2(SIG_DEPTH);

  logic                 start;
  logic                 core_res_n;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      instr;
  logic                 dmem_wr_en;
  logic [XLEN-1:0]      dmem_wr_addr;
  logic [XLEN-1:0]      dmem_wr_data;
  logic [IdxW-1:0]      sig_rd_idx;
  logic [XLEN-1:0]      sig_rd_addr;
  logic [XLEN-1:0]      sig_rd_data;
  logic [IdxW:0]        sig_count;
  logic [1:0]           state;
  logic                 done;
  logic                 halted;
  logic                 timeout;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] wr_total;

  modport master (
    output start, pc, instr, dmem_wr_en, dmem_wr_addr, dmem_wr_data, sig_rd_idx,
    input  core_res_n, sig_rd_addr, sig_rd_data, sig_count, state, done, halted, timeout,
           overflow, cycle_count, wr_total
  );

  modport slave (
    input  start, pc, instr, dmem_wr_en, dmem_wr_addr, dmem_wr_data, sig_rd_idx,
    output core_res_n, sig_rd_addr, sig_rd_data, sig_count, state, done, halted, timeout,
           overflow, cycle_count, wr_total
  );
endinterface

// File: rtl/signature_buffer.sv
// Capture array of {addr, data} pairs with fill pointer, sticky overflow and comb read port.
module signature_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IdxW = $clog2(DEPTH),
  localparam int unsigned CntW = IdxW + 1
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [XLEN-1:0] rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [CntW-1:0] count_o,
  output logic            overflow_o
);
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full;
  logic            rd_hit;

  assign full = (count_q == CntW'(DEPTH));

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (wr_en) begin
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: slots at or beyond count_q are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      addr_mem[count_q[IdxW-1:0]] <= wr_addr_i;
      data_mem[count_q[IdxW-1:0]] <= wr_data_i;
    end
  end

  assign rd_hit     = ({1'b0, rd_idx_i} < count_q);
  assign rd_addr_o  = rd_hit ? addr_mem[rd_idx_i] : '0;
  assign rd_data_o  = rd_hit ? data_mem[rd_idx_i] : '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for riscv_32i: reset sequencing, timeout, halt detection, write capture.
module riscv_run_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 112,
  parameter int unsigned HALT_REPEAT  = 2,
  parameter int unsigned SIG_DEPTH    = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic             clk,
  input logic             res_n,
  riscv_run_ctrl_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
  localparam logic [CNT_WIDTH-1:0] MaxCyc  = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HaltRep = CNT_WIDTH'(HALT_REPEAT);
  localparam logic [CNT_WIDTH-1:0] RstLoad = CNT_WIDTH'(RESET_CYCLES - 1);

  run_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, wr_total_q, wr_total_d;
  logic [CNT_WIDTH-1:0] rst_cnt_q, rst_cnt_d, same_q, same_d;
  logic [CNT_WIDTH-1:0] cycle_nxt, same_nxt;
  logic [XLEN-1:0]      prev_pc_q, prev_pc_d;
  logic                 prev_vld_q, prev_vld_d, halted_q, halted_d, timeout_q, timeout_d;
  logic                 run, start_acc, pc_repeat, halt_hit, time_hit;

  assign run       = (state_q == StRun);
  assign start_acc = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign pc_repeat = prev_vld_q && (bus.pc == prev_pc_q);
  assign same_nxt  = !pc_repeat ? '0 : ((same_q == CntMax) ? same_q : same_q + 1'b1);
  assign cycle_nxt = (cycle_q == CntMax) ? cycle_q : cycle_q + 1'b1;
  assign halt_hit  = run && ((bus.instr == XLEN'(INSTR_ECALL)) ||
                             (bus.instr == XLEN'(INSTR_EBREAK)) || (same_nxt == HaltRep));
  assign time_hit  = run && (cycle_nxt == MaxCyc);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= StIdle;
      cycle_q    <= '0;
      wr_total_q <= '0;
      rst_cnt_q  <= '0;
      same_q     <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      wr_total_q <= wr_total_d;
      rst_cnt_q  <= rst_cnt_d;
      same_q     <= same_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StReset;
      StReset: if (rst_cnt_q == '0) state_d = StRun;
      StRun:   if (halt_hit || time_hit) state_d = StDone;
      StDone:  if (bus.start) state_d = StReset;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cycle_d    = cycle_q;
    wr_total_d = wr_total_q;
    rst_cnt_d  = rst_cnt_q;
    same_d     = same_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    if (start_acc) begin
      cycle_d    = '0;
      wr_total_d = '0;
      rst_cnt_d  = RstLoad;
      same_d     = '0;
      prev_pc_d  = '0;
      prev_vld_d = 1'b0;
      halted_d   = 1'b0;
      timeout_d  = 1'b0;
    end else if (state_q == StReset) begin
      if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - 1'b1;
    end else if (run) begin
      cycle_d    = cycle_nxt;
      same_d     = same_nxt;
      prev_pc_d  = bus.pc;
      prev_vld_d = 1'b1;
      if (bus.dmem_wr_en && (wr_total_q != CntMax)) wr_total_d = wr_total_q + 1'b1;
      // Halt takes priority when it coincides with the timeout cycle.
      halted_d   = halt_hit;
      timeout_d  = time_hit && !halt_hit;
    end
  end

  always_comb begin
    bus.core_res_n  = run;
    bus.state       = state_q;
    bus.done        = (state_q == StDone);
    bus.halted      = halted_q;
    bus.timeout     = timeout_q;
    bus.cycle_count = cycle_q;
    bus.wr_total    = wr_total_q;
  end

  signature_buffer #(
    .XLEN  (XLEN),
    .DEPTH (SIG_DEPTH)
  ) u_sig_buf (
    .clk        (clk),
    .res_n      (res_n),
    .clear      (start_acc),
    .wr_en      (run && bus.dmem_wr_en),
    .wr_addr_i  (bus.dmem_wr_addr),
    .wr_data_i  (bus.dmem_wr_data),
    .rd_idx_i   (bus.sig_rd_idx),
    .rd_addr_o  (bus.sig_rd_addr),
    .rd_data_o  (bus.sig_rd_data),
    .count_o    (bus.sig_count),
    .overflow_o (bus.overflow)
  );

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Randomised and directed bench for riscv_run_ctrl against a per-run outcome model.
module tb_riscv_run_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RC   = 4;
  localparam int unsigned MAXC = 112;
  localparam int unsigned HR   = 2;
  localparam int unsigned CW   = 16;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, wen = 1'b0;
  logic [31:0] pc = '0, instr = NOP, wa = '0, wd = '0;
  logic [2:0]  idx8 = '0;
  logic [3:0]  idx16 = '0;

  riscv_run_ctrl_if #(.XLEN(XLEN), .SIG_DEPTH(8), .CNT_WIDTH(CW)) b8 ();
  riscv_run_ctrl_if #(.XLEN(XLEN), .SIG_DEPTH(16), .CNT_WIDTH(CW)) b16 ();

  assign b8.start = start;         assign b16.start = start;
  assign b8.pc = pc;               assign b16.pc = pc;
  assign b8.instr = instr;         assign b16.instr = instr;
  assign b8.dmem_wr_en = wen;      assign b16.dmem_wr_en = wen;
  assign b8.dmem_wr_addr = wa;     assign b16.dmem_wr_addr = wa;
  assign b8.dmem_wr_data = wd;     assign b16.dmem_wr_data = wd;
  assign b8.sig_rd_idx = idx8;     assign b16.sig_rd_idx = idx16;

  riscv_run_ctrl #(.XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .HALT_REPEAT(HR),
                   .SIG_DEPTH(8), .CNT_WIDTH(CW)) dut8 (.clk(clk), .res_n(res_n), .bus(b8.slave));
  riscv_run_ctrl #(.XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .HALT_REPEAT(HR),
                   .SIG_DEPTH(16), .CNT_WIDTH(CW)) dut16 (.clk(clk), .res_n(res_n),
                   .bus(b16.slave));

  // Per-RUN-cycle stimulus, index 1 = first RUN cycle.
  logic [31:0] s_pc [0:127];
  logic [31:0] s_in [0:127];
  logic [31:0] s_wa [0:127];
  logic [31:0] s_wd [0:127];
  bit          s_we [0:127];

  logic [63:0] exp_q [$];
  int          exp_end;
  bit          exp_halt, exp_to;
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a run: the first cycle whose instruction halts or whose PC equals each of the
  // previous HR PCs, else the MAXC-th cycle; writes up to and including that cycle are kept.
  task automatic model();
    exp_q.delete();
    exp_end = 0; exp_halt = 0; exp_to = 0;
    for (int k = 1; k <= int'(MAXC) && exp_end == 0; k++) begin
      bit loop_h;
      loop_h = (k > int'(HR));
      if (loop_h)
        for (int j = 1; j <= int'(HR); j++) if (s_pc[k-j] != s_pc[k]) loop_h = 0;
      if (s_we[k]) exp_q.push_back({s_wa[k], s_wd[k]});
      if (s_in[k] == ECALL || s_in[k] == EBREAK || loop_h) begin
        exp_end = k; exp_halt = 1;
      end else if (k == int'(MAXC)) begin
        exp_end = k; exp_to = 1;
      end
    end
  endtask

  task automatic fill_linear(input bit rand_wr);
    for (int k = 0; k < 128; k++) begin
      s_pc[k] = 32'(4 * (k - 1));
      s_in[k] = NOP;
      s_we[k] = rand_wr ? ($urandom_range(0, 2) == 0) : 1'b0;
      s_wa[k] = $urandom() & 32'hffff_fffc;
      s_wd[k] = $urandom();
    end
  endtask

  task automatic fill_random();
    s_pc[0] = 32'h100;
    for (int k = 1; k < 128; k++) begin
      s_pc[k] = ($urandom_range(0, 3) == 0) ? s_pc[k-1] : s_pc[k-1] + 32'd4;
      case ($urandom_range(0, 39))
        0:       s_in[k] = ECALL;
        1:       s_in[k] = EBREAK;
        default: s_in[k] = {$urandom_range(0, 32'h1ff_ffff) , 7'h13};
      endcase
      s_we[k] = ($urandom_range(0, 2) == 0);
      s_wa[k] = $urandom() & 32'hffff_fffc;
      s_wd[k] = $urandom();
    end
  endtask

  task automatic chk_zero(input string tag);
    idx8 = 3'd0; idx16 = 4'd0;
    #1;
    check({tag, ".state"}, 64'(b8.state), 0);
    check({tag, ".core_res_n"}, 64'(b8.core_res_n), 0);
    check({tag, ".done"}, 64'(b8.done), 0);
    check({tag, ".halted"}, 64'(b8.halted), 0);
    check({tag, ".timeout"}, 64'(b8.timeout), 0);
    check({tag, ".overflow"}, 64'(b8.overflow), 0);
    check({tag, ".cycle_count"}, 64'(b8.cycle_count), 0);
    check({tag, ".wr_total"}, 64'(b8.wr_total), 0);
    check({tag, ".sig_count"}, 64'(b8.sig_count), 0);
    check({tag, ".rd_addr"}, 64'(b8.sig_rd_addr), 0);
    check({tag, ".rd_data"}, 64'(b8.sig_rd_data), 0);
    check({tag, ".d16_state"}, 64'(b16.state), 0);
    check({tag, ".d16_sig_count"}, 64'(b16.sig_count), 0);
  endtask

  task automatic do_run(input string tag);
    int k;
    bit fin;
    int n8, n16;
    model();
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".st_reset"}, 64'(b8.state), 1);
    check({tag, ".clr_cc"}, 64'(b8.cycle_count), 0);
    check({tag, ".clr_wt"}, 64'(b8.wr_total), 0);
    check({tag, ".clr_sc"}, 64'(b8.sig_count), 0);
    check({tag, ".clr_flags"}, 64'({b8.done, b8.halted, b8.timeout, b8.overflow}), 0);
    check({tag, ".crn_low0"}, 64'(b8.core_res_n), 0);
    for (int i = 1; i < int'(RC); i++) begin
      step();
      check({tag, ".crn_low"}, 64'(b8.core_res_n), 0);
    end
    step();
    check({tag, ".st_run"}, 64'(b8.state), 2);
    check({tag, ".crn_high"}, 64'(b8.core_res_n), 1);
    k = 1; fin = 0;
    while (!fin && k <= int'(MAXC) + 4) begin
      pc = s_pc[k]; instr = s_in[k]; wen = s_we[k]; wa = s_wa[k]; wd = s_wd[k];
      start = 1'($urandom_range(0, 1));
      step();
      if (b8.state == 2'd3) fin = 1;
      else k++;
    end
    start = 1'b0; wen = 1'b0; instr = NOP;
    check({tag, ".end_cycle"}, 64'(k), 64'(exp_end));
    check({tag, ".done"}, 64'(b8.done), 1);
    check({tag, ".crn_done"}, 64'(b8.core_res_n), 0);
    check({tag, ".cycle_count"}, 64'(b8.cycle_count), 64'(exp_end));
    check({tag, ".halted"}, 64'(b8.halted), 64'(exp_halt));
    check({tag, ".timeout"}, 64'(b8.timeout), 64'(exp_to));
    check({tag, ".wr_total"}, 64'(b8.wr_total), 64'(exp_q.size()));
    n8  = (exp_q.size() > 8) ? 8 : exp_q.size();
    n16 = (exp_q.size() > 16) ? 16 : exp_q.size();
    check({tag, ".sig_count8"}, 64'(b8.sig_count), 64'(n8));
    check({tag, ".overflow8"}, 64'(b8.overflow), 64'(exp_q.size() > 8));
    check({tag, ".sig_count16"}, 64'(b16.sig_count), 64'(n16));
    check({tag, ".overflow16"}, 64'(b16.overflow), 64'(exp_q.size() > 16));
    for (int i = 0; i < 8; i++) begin
      idx8 = 3'(i);
      #1;
      check({tag, ".rd8"}, {b8.sig_rd_addr, b8.sig_rd_data}, (i < n8) ? exp_q[i] : 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      idx16 = 4'(i);
      #1;
      check({tag, ".rd16"}, {b16.sig_rd_addr, b16.sig_rd_data}, (i < n16) ? exp_q[i] : 64'd0);
    end
  endtask

  initial begin
    int fib [10];
    fib = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

    step(); step();
    chk_zero("reset");
    res_n = 1'b1;

    fill_linear(1);
    s_in[10] = ECALL;
    do_run("ecall");
    check("ecall.cc10", 64'(b8.cycle_count), 10);
    check("ecall.flags", 64'({b8.halted, b8.timeout}), 64'(2'b10));

    fill_linear(1);
    for (int k = 4; k < 128; k++) s_pc[k] = 32'h0C;
    do_run("selfloop");
    check("selfloop.cc6", 64'(b8.cycle_count), 6);

    fill_linear(1);
    do_run("timeout");
    check("timeout.cc112", 64'(b8.cycle_count), 112);
    check("timeout.flag", 64'(b8.timeout), 1);

    fill_linear(0);
    s_in[MAXC] = EBREAK;
    do_run("halt_at_max");
    check("halt_at_max.flags", 64'({b8.halted, b8.timeout}), 64'(2'b10));

    fill_linear(0);
    for (int i = 0; i < 10; i++) begin
      s_we[i+1] = 1'b1; s_wa[i+1] = 32'(4 * i); s_wd[i+1] = 32'(fib[i]);
    end
    s_in[11] = ECALL;
    do_run("fib");
    idx8 = 3'd7; idx16 = 4'd10;
    #1;
    check("fib.idx7", {b8.sig_rd_addr, b8.sig_rd_data}, {32'h1C, 32'd21});
    check("fib.idx10_16", {b16.sig_rd_addr, b16.sig_rd_data}, 64'd0);
    check("fib.cnt8", 64'(b8.sig_count), 8);
    check("fib.cnt16", 64'(b16.sig_count), 10);
    check("fib.wt", 64'(b8.wr_total), 10);
    check("fib.ovf", 64'(b8.overflow), 1);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_run($sformatf("rand%0d", r));
    end

    fill_linear(1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (RC + 5) begin
      wen = 1'b1; wa = $urandom(); wd = $urandom(); pc = pc + 32'd4;
      step();
    end
    wen = 1'b0;
    check("midrun.in_run", 64'(b8.state), 2);
    res_n = 1'b0;
    step();
    chk_zero("midrun_rst");
    res_n = 1'b1;

    fill_random();
    do_run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
